// File: rtl/orb_field_if.sv
// Pixel/frame handshake bundle between the sync generator side and orb_field_engine.
// The master drives timing, pixel and control inputs; the slave returns packed VGA pins and busy.
interface orb_field_if #(
  parameter int COORD_W = 10
) ();
  logic               frame_tick;
  logic [1:0]         speed;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               video_active;
  logic               hsync_in;
  logic               vsync_in;
  logic [7:0]         uo_out;
  logic               busy;

  modport master (
    output frame_tick, speed, pix_x, pix_y, video_active, hsync_in, vsync_in,
    input  uo_out, busy
  );

  modport slave (
    input  frame_tick, speed, pix_x, pix_y, video_active, hsync_in, vsync_in,
    output uo_out, busy
  );
endinterface

// File: rtl/orb_field_engine.sv
// Bouncing-orb squared-distance field renderer with a 3-stage pixel pipeline and ring palette.
// Define PALETTE_CYCLE_EN to rotate the palette by frame_cnt[5:3]; otherwise the table is static.
module orb_field_engine #(
  parameter int NUM_ORBS = 2,
  parameter int COORD_W  = 10,
  parameter int SHIFT    = 4,
  parameter int RING_LSB = 5,
  parameter int X_MAX    = 640,
  parameter int Y_MAX    = 480,
  parameter int MARGIN   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  orb_field_if.slave  bus
);
  localparam int DIFF_W  = COORD_W - SHIFT;
  localparam int TERM_W  = 2 * DIFF_W;
  localparam int SQ_W    = TERM_W + 1;
  localparam int FIELD_W = SQ_W + $clog2(NUM_ORBS);
  localparam int IDX_W   = (NUM_ORBS > 1) ? $clog2(NUM_ORBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ORBS - 1);

  typedef enum logic {IDLE, UPD} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [7:0]         frame_cnt_reg, frame_cnt_next;

  logic [COORD_W-1:0] orb_x_reg [NUM_ORBS];
  logic [COORD_W-1:0] orb_y_reg [NUM_ORBS];
  logic               dir_x_reg [NUM_ORBS];
  logic               dir_y_reg [NUM_ORBS];

  logic [COORD_W-1:0] step;
  logic [COORD_W:0]   move_x, move_y;

  // Returns {new_dir, new_pos}; integer math keeps the clamp free of wrap-around.
  function automatic logic [COORD_W:0] move_axis(input logic [COORD_W-1:0] pos,
                                                 input logic dir,
                                                 input logic [COORD_W-1:0] stp,
                                                 input int lim);
    int p, s, hi, lo, np;
    logic nd;
    p  = int'(pos);
    s  = int'(stp);
    hi = lim - MARGIN;
    lo = MARGIN;
    np = p;
    nd = dir;
    if (dir) begin
      if (p >= hi)          nd = 1'b0;
      else if (p + s >= hi) np = hi;
      else                  np = p + s;
    end else begin
      if (p <= lo)          nd = 1'b1;
      else if (p <= lo + s) np = lo;
      else                  np = p - s;
    end
    return {nd, COORD_W'(np)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.frame_tick) begin
          state_next     = UPD;
          idx_next       = '0;
          frame_cnt_next = frame_cnt_reg + 8'd1;
        end
      end
      UPD: begin
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == UPD);

  // One shared move datapath serves whichever orb idx_reg points at.
  always_comb begin
    step   = (bus.speed == 2'd0) ? '0 : COORD_W'(bus.speed) + COORD_W'(idx_reg);
    move_x = move_axis(orb_x_reg[idx_reg], dir_x_reg[idx_reg], step, X_MAX);
    move_y = move_axis(orb_y_reg[idx_reg], dir_y_reg[idx_reg], step, Y_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ORBS; k++) begin
        orb_x_reg[k] <= COORD_W'(300 + 40 * k);
        orb_y_reg[k] <= COORD_W'(200 + 80 * k);
        dir_x_reg[k] <= (k % 2 == 0);
        dir_y_reg[k] <= 1'b1;
      end
    end else if (state_reg == UPD) begin
      for (int k = 0; k < NUM_ORBS; k++) begin
        if (idx_reg == IDX_W'(k)) begin
          orb_x_reg[k] <= move_x[COORD_W-1:0];
          dir_x_reg[k] <= move_x[COORD_W];
          orb_y_reg[k] <= move_y[COORD_W-1:0];
          dir_y_reg[k] <= move_y[COORD_W];
        end
      end
    end
  end

  logic [SQ_W-1:0] sq_all [NUM_ORBS];

  for (genvar gi = 0; gi < NUM_ORBS; gi++) begin : g_orb
    logic [COORD_W-1:0] ax, ay;
    logic [DIFF_W-1:0]  dx_reg, dy_reg;
    logic [TERM_W-1:0]  dx_w, dy_w;
    logic [SQ_W-1:0]    sq_reg;

    assign ax   = (bus.pix_x >= orb_x_reg[gi]) ? bus.pix_x - orb_x_reg[gi] : orb_x_reg[gi] - bus.pix_x;
    assign ay   = (bus.pix_y >= orb_y_reg[gi]) ? bus.pix_y - orb_y_reg[gi] : orb_y_reg[gi] - bus.pix_y;
    assign dx_w = {{DIFF_W{1'b0}}, dx_reg};
    assign dy_w = {{DIFF_W{1'b0}}, dy_reg};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dx_reg <= '0;
        dy_reg <= '0;
        sq_reg <= '0;
      end else begin
        dx_reg <= DIFF_W'(ax >> SHIFT);
        dy_reg <= DIFF_W'(ay >> SHIFT);
        sq_reg <= {1'b0, dx_w * dx_w} + {1'b0, dy_w * dy_w};
      end
    end

    assign sq_all[gi] = sq_reg;
  end

  // {video_active, hsync, vsync} travelling alongside stages 1 and 2.
  logic [2:0]         sync1_reg, sync2_reg;
  logic [7:0]         uo_out_reg;
  logic [FIELD_W-1:0] field_sum;
  logic [3:0]         pal_idx;
  logic [2:0]         phase;
  logic [5:0]         rgb;

  function automatic logic [5:0] base_colour(input logic [2:0] c);
    case (c)
      3'd0:    return 6'b11_11_11;
      3'd1:    return 6'b11_11_00;
      3'd2:    return 6'b11_00_00;
      3'd3:    return 6'b10_00_01;
      3'd4:    return 6'b00_00_11;
      3'd5:    return 6'b00_10_11;
      3'd6:    return 6'b00_11_00;
      default: return 6'b00_01_00;
    endcase
  endfunction

  always_comb begin
    field_sum = '0;
    for (int k = 0; k < NUM_ORBS; k++) begin
      field_sum = field_sum + FIELD_W'(sq_all[k]);
    end
    pal_idx = 4'(field_sum >> RING_LSB);
`ifdef PALETTE_CYCLE_EN
    phase = frame_cnt_reg[5:3];
`else
    phase = 3'd0;
`endif
    rgb = '0;
    if (sync2_reg[2] && !pal_idx[3]) begin
      rgb = base_colour(pal_idx[2:0] + phase);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      uo_out_reg <= '0;
    end else begin
      sync1_reg  <= {bus.video_active, bus.hsync_in, bus.vsync_in};
      sync2_reg  <= sync1_reg;
      // rgb = {r1,r0,g1,g0,b1,b0}
      uo_out_reg <= {sync2_reg[1], rgb[0], rgb[2], rgb[4], sync2_reg[0], rgb[1], rgb[3], rgb[5]};
    end
  end

  assign bus.uo_out = uo_out_reg;
endmodule

// File: tb/tb_orb_field_engine.sv
// Randomized self-checking bench for orb_field_engine against an integer reference model.
// Honours PALETTE_CYCLE_EN the same way as the design.
module tb_orb_field_engine;
  localparam int NUM_ORBS = 2;
  localparam int COORD_W  = 10;
  localparam int SHIFT    = 4;
  localparam int RING_LSB = 5;
  localparam int X_MAX    = 640;
  localparam int Y_MAX    = 480;
  localparam int MARGIN   = 10;

  logic clk;
  logic rst_n;
  orb_field_if #(.COORD_W(COORD_W)) bus ();

  orb_field_engine #(
    .NUM_ORBS(NUM_ORBS), .COORD_W(COORD_W), .SHIFT(SHIFT), .RING_LSB(RING_LSB),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .MARGIN(MARGIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int mx [NUM_ORBS];
  int my [NUM_ORBS];
  int mdx[NUM_ORBS];
  int mdy[NUM_ORBS];
  int mfc;
  int exp_q[$];

  int pal_r[8] = '{3, 3, 3, 2, 0, 0, 0, 0};
  int pal_g[8] = '{3, 3, 0, 0, 0, 2, 3, 1};
  int pal_b[8] = '{3, 0, 0, 1, 3, 3, 0, 0};

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_ORBS; k++) begin
      mx[k] = 300 + 40 * k;
      my[k] = 200 + 80 * k;
      mdx[k] = (k % 2 == 0) ? 1 : 0;
      mdy[k] = 1;
    end
    mfc = 0;
  endfunction

  function automatic void model_axis(inout int pos, inout int dir, input int st, input int lim);
    if (dir == 1) begin
      if (pos >= lim - MARGIN) dir = 0;
      else pos = (pos + st < lim - MARGIN) ? pos + st : lim - MARGIN;
    end else begin
      if (pos <= MARGIN) dir = 1;
      else pos = (pos - st > MARGIN) ? pos - st : MARGIN;
    end
  endfunction

  function automatic void model_frame(input int spd);
    for (int k = 0; k < NUM_ORBS; k++) begin
      int st;
      st = (spd == 0) ? 0 : spd + k;
      model_axis(mx[k], mdx[k], st, X_MAX);
      model_axis(my[k], mdy[k], st, Y_MAX);
    end
    mfc = (mfc + 1) % 256;
  endfunction

  function automatic int model_phase();
`ifdef PALETTE_CYCLE_EN
    return (mfc >> 3) & 7;
`else
    return 0;
`endif
  endfunction

  function automatic int expect_pix(int x, int y, int act, int hs, int vs);
    int f, idx, r, g, b, c, ax, ay;
    f = 0;
    for (int k = 0; k < NUM_ORBS; k++) begin
      ax = ((x > mx[k]) ? x - mx[k] : mx[k] - x) >> SHIFT;
      ay = ((y > my[k]) ? y - my[k] : my[k] - y) >> SHIFT;
      f += ax * ax + ay * ay;
    end
    idx = (f >> RING_LSB) % 16;
    r = 0; g = 0; b = 0;
    if (act != 0 && idx < 8) begin
      c = (idx + model_phase()) % 8;
      r = pal_r[c]; g = pal_g[c]; b = pal_b[c];
    end
    return (hs << 7) | ((b & 1) << 6) | ((g & 1) << 5) | ((r & 1) << 4) |
           (vs << 3) | ((b >> 1) << 2) | ((g >> 1) << 1) | (r >> 1);
  endfunction

  task automatic check_orbs(input string tag);
    for (int k = 0; k < NUM_ORBS; k++) begin
      check_val($sformatf("%s_x%0d", tag, k), int'(dut.orb_x_reg[k]), mx[k]);
      check_val($sformatf("%s_y%0d", tag, k), int'(dut.orb_y_reg[k]), my[k]);
      check_val($sformatf("%s_dx%0d", tag, k), int'(dut.dir_x_reg[k]), mdx[k]);
      check_val($sformatf("%s_dy%0d", tag, k), int'(dut.dir_y_reg[k]), mdy[k]);
    end
    check_val($sformatf("%s_fcnt", tag), int'(dut.frame_cnt_reg), mfc);
  endtask

  task automatic idle_inputs();
    bus.frame_tick = 1'b0; bus.speed = 2'd0;
    bus.pix_x = '0; bus.pix_y = '0;
    bus.video_active = 1'b0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.frame_tick = 1'($urandom); bus.speed = 2'($urandom);
    bus.pix_x = COORD_W'($urandom); bus.pix_y = COORD_W'($urandom);
    bus.video_active = 1'b1; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_val("rst_uo_out", int'(bus.uo_out), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    check_orbs("rst");
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_frame(input int spd, input bit hold2);
    int cnt;
    bus.speed = 2'(spd);
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    if (!hold2) bus.frame_tick = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
    end
    check_val("busy_cycles", cnt, NUM_ORBS);
    model_frame(spd);
    check_orbs("frame");
    @(posedge clk); #1;
  endtask

  task automatic pix_begin();
    exp_q = {};
    exp_q.push_back(-1);
    exp_q.push_back(-1);
  endtask

  task automatic pix_step(input int x, input int y, input int act, input int hs, input int vs);
    int e;
    bus.pix_x = COORD_W'(x); bus.pix_y = COORD_W'(y);
    bus.video_active = 1'(act); bus.hsync_in = 1'(hs); bus.vsync_in = 1'(vs);
    exp_q.push_back(expect_pix(x, y, act, hs, vs));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    if (e >= 0) check_val("uo_out", int'(bus.uo_out), e);
  endtask

  task automatic pix_end();
    pix_step(0, 0, 0, 0, 0);
    pix_step(0, 0, 0, 0, 0);
    exp_q = {};
  endtask

  task automatic pix_random(input int n);
    pix_begin();
    for (int i = 0; i < n; i++) begin
      pix_step($urandom_range(0, X_MAX - 1), $urandom_range(0, Y_MAX - 1),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    pix_end();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    do_reset();

    // Latency and blanking at the reset positions: field 29 -> white.
    pix_begin();
    pix_step(300, 200, 1, 1, 0);
    pix_step(300, 200, 1, 0, 0);
    pix_step(300, 200, 1, 0, 0);
    check_val("latency_white_hs", int'(bus.uo_out), 8'hF7);
    pix_step(300, 200, 0, 0, 1);
    pix_step(300, 200, 0, 0, 0);
    pix_step(300, 200, 0, 0, 0);
    check_val("blank_vsync", int'(bus.uo_out), 8'h08);
    pix_end();
    pix_random(40);

    do_frame(2, 1'b0);
    check_val("frame1_x0", int'(dut.orb_x_reg[0]), 302);
    check_val("frame1_y0", int'(dut.orb_y_reg[0]), 202);
    check_val("frame1_x1", int'(dut.orb_x_reg[1]), 337);
    check_val("frame1_y1", int'(dut.orb_y_reg[1]), 283);

    do_reset();
    for (int i = 0; i < 165; i++) do_frame(2, 1'b0);
    check_val("bounce_x165", int'(dut.orb_x_reg[0]), 630);
    do_frame(2, 1'b0);
    check_val("bounce_x166", int'(dut.orb_x_reg[0]), 630);
    check_val("bounce_dir166", int'(dut.dir_x_reg[0]), 0);
    do_frame(2, 1'b0);
    check_val("bounce_x167", int'(dut.orb_x_reg[0]), 628);

    // Eight frozen frames: phase 1 when cycling, otherwise static white.
    do_reset();
    for (int i = 0; i < 8; i++) do_frame(0, 1'b1);
    pix_begin();
    for (int i = 0; i < 3; i++) pix_step(300, 200, 1, 0, 0);
`ifdef PALETTE_CYCLE_EN
    check_val("palette_cycle", int'(bus.uo_out), 8'h33);
`else
    check_val("palette_static", int'(bus.uo_out), 8'h77);
`endif
    pix_end();

    for (int it = 0; it < 30; it++) begin
      int nf, spd;
      spd = $urandom_range(0, 3);
      nf = $urandom_range(1, 12);
      for (int f = 0; f < nf; f++) do_frame(spd, 1'($urandom));
      pix_random(16);
    end

    // Reset in the middle of an update abandons it.
    bus.speed = 2'd3;
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    check_val("midupd_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midupd_rst_busy", int'(bus.busy), 0);
    check_val("midupd_rst_uo", int'(bus.uo_out), 0);
    check_orbs("midupd_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    do_frame(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
